rf_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order writeback path (writeback-stage rf_wr_* outputs);
  - a long-latency result source (divider, non-blocking load return) that completes out of order.
- Buffers long-latency results in a small FIFO and applies fixed priority to writeback, with a starvation guard.
- On a flush, drains the buffered results, issuing a scoreboard clear-dirty for each dropped entry.
- Sits between wb_stage / the long-latency unit and the register file / scoreboard.

---
 rtl/rf_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port between the
// in-order writeback path and an out-of-order long-latency result source.
// Long-latency results are buffered in a small FIFO; writeback has fixed
// priority, with a starvation counter that forces the FIFO head out after
// STARVE_MAX consecutive writeback wins. A flush drains the FIFO, issuing
// one scoreboard clear-dirty per dropped entry.
//
// Handshake: a long-latency result transfers in any cycle where
// ll_valid & ll_ready are both high at the rising clock edge. ll_ready does
// not depend on ll_valid. The producer keeps ll_valid and its payload
// stable until the transfer. On the writeback side, wb_gnt=0 while
// wb_wr_en=1 means the write did not happen and must be presented again.
module rf_wr_arbiter #(
   parameter int TAG_WIDTH  = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wb_wr_en,
   input  logic [TAG_WIDTH-1:0] wb_wr_tag,
   input  logic [4:0]           wb_wr_addr,
   input  logic [31:0]          wb_wr_data,
   output logic                 wb_gnt,
   input  logic                 ll_valid,
   output logic                 ll_ready,
   input  logic [TAG_WIDTH-1:0] ll_tag,
   input  logic [4:0]           ll_addr,
   input  logic [31:0]          ll_data,
   input  logic                 flush_ll,
   output logic                 rf_wr_en,
   output logic [TAG_WIDTH-1:0] rf_wr_tag,
   output logic [4:0]           rf_wr_addr,
   output logic [31:0]          rf_wr_data,
   output logic                 ll_clr_dirty_en,
   output logic [4:0]           ll_clr_dirty_addr,
   output logic                 draining
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [PW:0]   DEPTH_L  = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   ONE_L    = (PW+1)'(1);
   localparam logic [CW-1:0] STARVE_L = CW'(STARVE_MAX);

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t state, state_nxt;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [TAG_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
   logic [4:0]           fifo_addr [FIFO_DEPTH];
   logic [31:0]          fifo_data [FIFO_DEPTH];
   logic [PW:0]          wr_ptr, rd_ptr, count;
   logic                 empty, full;
   logic                 push, pop, bypass, accept;
   logic [CW-1:0]        cnt, cnt_nxt;

   logic [TAG_WIDTH-1:0] head_tag;
   logic [4:0]           head_addr;
   logic [31:0]          head_data;

   assign count     = wr_ptr - rd_ptr;
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_L);
   assign head_tag  = fifo_tag[rd_ptr[PW-1:0]];
   assign head_addr = fifo_addr[rd_ptr[PW-1:0]];
   assign head_data = fifo_data[rd_ptr[PW-1:0]];

   // ll_ready uses pre-pop occupancy, so a full FIFO refuses even when popping
   assign ll_ready = (state == RUN) & ~full & ~flush_ll;
   assign accept   = ll_valid & ll_ready;
   assign draining = (state == DRAIN);

   // Next state, write-port selection, FIFO push/pop and starvation count
   always_comb begin
      state_nxt         = state;
      cnt_nxt           = cnt;
      pop               = 1'b0;
      bypass            = 1'b0;
      wb_gnt            = 1'b1;
      rf_wr_en          = 1'b0;
      rf_wr_tag         = '0;
      rf_wr_addr        = '0;
      rf_wr_data        = '0;
      ll_clr_dirty_en   = 1'b0;
      ll_clr_dirty_addr = '0;
      case (state)
         RUN: begin
            if (flush_ll && !empty) begin
               // Flush takes over the buffered results; none are written
               state_nxt = DRAIN;
               cnt_nxt   = '0;
               if (wb_wr_en) begin
                  rf_wr_en   = 1'b1;
                  rf_wr_tag  = wb_wr_tag;
                  rf_wr_addr = wb_wr_addr;
                  rf_wr_data = wb_wr_data;
               end
            end else if (!empty && cnt == STARVE_L) begin
               // Starvation guard: the FIFO head wins over writeback
               rf_wr_en   = 1'b1;
               rf_wr_tag  = head_tag;
               rf_wr_addr = head_addr;
               rf_wr_data = head_data;
               pop        = 1'b1;
               wb_gnt     = ~wb_wr_en;
               cnt_nxt    = '0;
            end else if (wb_wr_en) begin
               rf_wr_en   = 1'b1;
               rf_wr_tag  = wb_wr_tag;
               rf_wr_addr = wb_wr_addr;
               rf_wr_data = wb_wr_data;
               if (!empty && cnt != STARVE_L) cnt_nxt = cnt + 1'b1;
            end else if (!empty) begin
               rf_wr_en   = 1'b1;
               rf_wr_tag  = head_tag;
               rf_wr_addr = head_addr;
               rf_wr_data = head_data;
               pop        = 1'b1;
               cnt_nxt    = '0;
            end else if (accept) begin
               // Zero-latency bypass when nothing is buffered and port is free
               rf_wr_en   = 1'b1;
               rf_wr_tag  = ll_tag;
               rf_wr_addr = ll_addr;
               rf_wr_data = ll_data;
               bypass     = 1'b1;
            end
         end
         DRAIN: begin
            ll_clr_dirty_en   = 1'b1;
            ll_clr_dirty_addr = head_addr;
            pop               = 1'b1;
            cnt_nxt           = '0;
            if (count == ONE_L) state_nxt = RUN;
            if (wb_wr_en) begin
               rf_wr_en   = 1'b1;
               rf_wr_tag  = wb_wr_tag;
               rf_wr_addr = wb_wr_addr;
               rf_wr_data = wb_wr_data;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   assign push = accept & ~bypass;

   // State, pointer and starvation-counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= RUN;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FIFO payload storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_tag[wr_ptr[PW-1:0]]  <= ll_tag;
         fifo_addr[wr_ptr[PW-1:0]] <= ll_addr;
         fifo_data[wr_ptr[PW-1:0]] <= ll_data;
      end
   end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Testbench for rf_wr_arbiter: directed scenarios plus a randomized run
// checked against a queue-based behavioural model.
module tb_rf_wr_arbiter;

  localparam int TW     = 4;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic          clk;
  logic          reset_n;
  logic          wb_wr_en;
  logic [TW-1:0] wb_wr_tag;
  logic [4:0]    wb_wr_addr;
  logic [31:0]   wb_wr_data;
  logic          wb_gnt;
  logic          ll_valid;
  logic          ll_ready;
  logic [TW-1:0] ll_tag;
  logic [4:0]    ll_addr;
  logic [31:0]   ll_data;
  logic          flush_ll;
  logic          rf_wr_en;
  logic [TW-1:0] rf_wr_tag;
  logic [4:0]    rf_wr_addr;
  logic [31:0]   rf_wr_data;
  logic          ll_clr_dirty_en;
  logic [4:0]    ll_clr_dirty_addr;
  logic          draining;

  int checks;
  int failures;

  rf_wr_arbiter #(.TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wb_wr_en          (wb_wr_en),
    .wb_wr_tag         (wb_wr_tag),
    .wb_wr_addr        (wb_wr_addr),
    .wb_wr_data        (wb_wr_data),
    .wb_gnt            (wb_gnt),
    .ll_valid          (ll_valid),
    .ll_ready          (ll_ready),
    .ll_tag            (ll_tag),
    .ll_addr           (ll_addr),
    .ll_data           (ll_data),
    .flush_ll          (flush_ll),
    .rf_wr_en          (rf_wr_en),
    .rf_wr_tag         (rf_wr_tag),
    .rf_wr_addr        (rf_wr_addr),
    .rf_wr_data        (rf_wr_data),
    .ll_clr_dirty_en   (ll_clr_dirty_en),
    .ll_clr_dirty_addr (ll_clr_dirty_addr),
    .draining          (draining)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [4:0]    addr;
    logic [31:0]   data;
  } ent_t;

  ent_t m_q[$];        // buffered long-latency results, oldest first
  bit   m_drain;       // flush drain in progress
  int   m_cnt;         // consecutive writeback wins with entries waiting

  // expected outputs for the current cycle
  logic          exp_wr_en, exp_gnt, exp_ready, exp_clr_en, exp_drain;
  logic [TW-1:0] exp_tag;
  logic [4:0]    exp_addr, exp_clr_addr;
  logic [31:0]   exp_data;
  // model update pending for the next clock edge
  bit   n_pop, n_push, n_drain;
  int   n_cnt;
  ent_t n_entry;

  task automatic model_calc();
    bit accept;
    bit bypass;
    int sz;
    sz           = m_q.size();
    exp_wr_en    = 1'b0;
    exp_tag      = '0;
    exp_addr     = '0;
    exp_data     = '0;
    exp_gnt      = 1'b1;
    exp_clr_en   = 1'b0;
    exp_clr_addr = '0;
    exp_drain    = m_drain;
    exp_ready    = !m_drain && (sz < DEPTH) && !flush_ll;
    accept       = ll_valid && exp_ready;
    bypass       = 1'b0;
    n_pop        = 1'b0;
    n_cnt        = m_cnt;
    n_drain      = m_drain;
    if (m_drain) begin
      exp_clr_en   = 1'b1;
      exp_clr_addr = m_q[0].addr;
      n_pop        = 1'b1;
      n_cnt        = 0;
      n_drain      = (sz > 1);
      if (wb_wr_en) {exp_wr_en, exp_tag, exp_addr, exp_data} = {1'b1, wb_wr_tag, wb_wr_addr, wb_wr_data};
    end else if (flush_ll && sz > 0) begin
      n_drain = 1'b1;
      n_cnt   = 0;
      if (wb_wr_en) {exp_wr_en, exp_tag, exp_addr, exp_data} = {1'b1, wb_wr_tag, wb_wr_addr, wb_wr_data};
    end else if (sz > 0 && m_cnt >= STARVE) begin
      {exp_wr_en, exp_tag, exp_addr, exp_data} = {1'b1, m_q[0].tag, m_q[0].addr, m_q[0].data};
      exp_gnt = !wb_wr_en;
      n_pop   = 1'b1;
      n_cnt   = 0;
    end else if (wb_wr_en) begin
      {exp_wr_en, exp_tag, exp_addr, exp_data} = {1'b1, wb_wr_tag, wb_wr_addr, wb_wr_data};
      if (sz > 0) n_cnt = (m_cnt + 1 > STARVE) ? STARVE : m_cnt + 1;
    end else if (sz > 0) begin
      {exp_wr_en, exp_tag, exp_addr, exp_data} = {1'b1, m_q[0].tag, m_q[0].addr, m_q[0].data};
      n_pop = 1'b1;
      n_cnt = 0;
    end else if (accept) begin
      {exp_wr_en, exp_tag, exp_addr, exp_data} = {1'b1, ll_tag, ll_addr, ll_data};
      bypass = 1'b1;
    end
    n_push  = accept && !bypass;
    n_entry = '{tag: ll_tag, addr: ll_addr, data: ll_data};
  endtask

  task automatic model_commit();
    if (n_pop) void'(m_q.pop_front());
    if (n_push) m_q.push_back(n_entry);
    m_cnt   = n_cnt;
    m_drain = n_drain;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drain = 1'b0;
    m_cnt   = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet_inputs();
    wb_wr_en   = 1'b0;
    wb_wr_tag  = '0;
    wb_wr_addr = '0;
    wb_wr_data = '0;
    ll_valid   = 1'b0;
    ll_tag     = '0;
    ll_addr    = '0;
    ll_data    = '0;
    flush_ll   = 1'b0;
  endtask

  // evaluate the model against current inputs after outputs settle
  task automatic settle();
    #1;
    model_calc();
  endtask

  // advance one clock and keep the model in step
  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] addr);
    wb_wr_en   = en;
    wb_wr_addr = addr;
    wb_wr_tag  = TW'($urandom);
    wb_wr_data = $urandom;
  endtask

  task automatic drive_ll(input logic vld, input logic [4:0] addr, input logic [31:0] data);
    ll_valid = vld;
    ll_addr  = addr;
    ll_data  = data;
    ll_tag   = TW'($urandom);
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if ({rf_wr_en, ll_clr_dirty_en, draining} !== 3'b000) begin
      failures++;
      $display("FAIL reset_enables got=%b exp=000", {rf_wr_en, ll_clr_dirty_en, draining});
    end
    checks++;
    if ({wb_gnt, ll_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_handshake got=%b exp=11", {wb_gnt, ll_ready});
    end
    checks++;
    if ({rf_wr_tag, rf_wr_addr, rf_wr_data, ll_clr_dirty_addr} !== '0) begin
      failures++;
      $display("FAIL reset_fields got tag=%h addr=%0d data=%h clr=%0d exp=0",
               rf_wr_tag, rf_wr_addr, rf_wr_data, ll_clr_dirty_addr);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_ll(1'b1, 5'd5, 32'hDEAD_BEEF);
    settle();
    checks++;
    if ({rf_wr_en, ll_ready, rf_wr_addr, rf_wr_data} !== {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL bypass got en=%b rdy=%b addr=%0d data=%h exp en=1 rdy=1 addr=5 data=deadbeef",
               rf_wr_en, ll_ready, rf_wr_addr, rf_wr_data);
    end
    tick();
    quiet_inputs();
    settle();
    checks++;
    if (rf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL bypass_not_queued got rf_wr_en=%b exp=0", rf_wr_en);
    end
    tick();
  endtask

  task automatic test_priority();
    drive_wb(1'b1, 5'd3);
    drive_ll(1'b1, 5'd7, 32'h0000_0777);
    settle();
    checks++;
    if ({rf_wr_en, wb_gnt, ll_ready, rf_wr_addr} !== {3'b111, 5'd3}) begin
      failures++;
      $display("FAIL prio_wb got en=%b gnt=%b rdy=%b addr=%0d exp en=1 gnt=1 rdy=1 addr=3",
               rf_wr_en, wb_gnt, ll_ready, rf_wr_addr);
    end
    tick();
    quiet_inputs();
    settle();
    checks++;
    if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd7, 32'h0000_0777}) begin
      failures++;
      $display("FAIL prio_buffered got en=%b addr=%0d data=%h exp en=1 addr=7 data=00000777",
               rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    settle();
    checks++;
    if (rf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL prio_empty got rf_wr_en=%b exp=0", rf_wr_en);
    end
    tick();
  endtask

  task automatic test_starvation();
    drive_wb(1'b1, 5'd1);
    drive_ll(1'b1, 5'd10, 32'hA0A0_0010);
    settle();
    tick();
    drive_ll(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < STARVE; i++) begin
      drive_wb(1'b1, 5'(20 + i));
      settle();
      checks++;
      if ({wb_gnt, rf_wr_en, rf_wr_addr} !== {2'b11, 5'(20 + i)}) begin
        failures++;
        $display("FAIL starve_wb_win%0d got gnt=%b en=%b addr=%0d exp gnt=1 en=1 addr=%0d",
                 i, wb_gnt, rf_wr_en, rf_wr_addr, 20 + i);
      end
      tick();
    end
    drive_wb(1'b1, 5'd30);
    settle();
    checks++;
    if ({wb_gnt, rf_wr_en, rf_wr_addr, rf_wr_data} !== {2'b01, 5'd10, 32'hA0A0_0010}) begin
      failures++;
      $display("FAIL starve_force got gnt=%b en=%b addr=%0d data=%h exp gnt=0 en=1 addr=10 data=a0a00010",
               wb_gnt, rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    settle();
    checks++;
    if ({wb_gnt, rf_wr_addr} !== {1'b1, 5'd30}) begin
      failures++;
      $display("FAIL starve_after got gnt=%b addr=%0d exp gnt=1 addr=30", wb_gnt, rf_wr_addr);
    end
    tick();
    quiet_inputs();
  endtask

  task automatic test_full_backpressure();
    bit accepted;
    int k;
    drive_wb(1'b1, 5'd2);
    drive_ll(1'b1, 5'd1, 32'h1);
    settle();
    tick();
    drive_ll(1'b1, 5'd2, 32'h2);
    settle();
    tick();
    drive_ll(1'b1, 5'd3, 32'h3);
    accepted = 1'b0;
    k = 0;
    while (!accepted && k < 12) begin
      settle();
      checks++;
      if (ll_ready !== (k == 4)) begin
        failures++;
        $display("FAIL full_ready k=%0d got=%b exp=%b", k, ll_ready, (k == 4));
      end
      if (k == 3) begin
        checks++;
        if ({wb_gnt, rf_wr_en, rf_wr_addr} !== {2'b01, 5'd1}) begin
          failures++;
          $display("FAIL full_force got gnt=%b en=%b addr=%0d exp gnt=0 en=1 addr=1",
                   wb_gnt, rf_wr_en, rf_wr_addr);
        end
      end
      accepted = ll_valid && ll_ready;
      tick();
      k++;
    end
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL full_accept_timeout got=not accepted exp=accepted within 12 cycles");
    end
    quiet_inputs();
    for (int i = 2; i <= 3; i++) begin
      settle();
      checks++;
      if ({rf_wr_en, rf_wr_addr} !== {1'b1, 5'(i)}) begin
        failures++;
        $display("FAIL full_order got en=%b addr=%0d exp en=1 addr=%0d", rf_wr_en, rf_wr_addr, i);
      end
      tick();
    end
  endtask

  task automatic fill_two(input logic [4:0] a0, input logic [4:0] a1);
    drive_wb(1'b1, 5'd1);
    drive_ll(1'b1, a0, 32'h9);
    settle();
    tick();
    drive_ll(1'b1, a1, 32'hC);
    settle();
    tick();
    quiet_inputs();
  endtask

  task automatic test_flush_drain();
    fill_two(5'd9, 5'd12);
    flush_ll = 1'b1;
    settle();
    checks++;
    if ({rf_wr_en, ll_ready, draining} !== 3'b000) begin
      failures++;
      $display("FAIL flush_cycle got en=%b rdy=%b drain=%b exp 000", rf_wr_en, ll_ready, draining);
    end
    tick();
    flush_ll = 1'b0;
    drive_ll(1'b1, 5'd20, 32'h20);
    settle();
    checks++;
    if ({ll_clr_dirty_en, ll_clr_dirty_addr, draining, ll_ready, rf_wr_en} !== {1'b1, 5'd9, 3'b100}) begin
      failures++;
      $display("FAIL drain1 got clr=%b addr=%0d drain=%b rdy=%b en=%b exp clr=1 addr=9 drain=1 rdy=0 en=0",
               ll_clr_dirty_en, ll_clr_dirty_addr, draining, ll_ready, rf_wr_en);
    end
    tick();
    flush_ll = 1'b1;  // ignored while draining
    drive_wb(1'b1, 5'd17);
    settle();
    checks++;
    if ({ll_clr_dirty_en, ll_clr_dirty_addr, draining, ll_ready} !== {1'b1, 5'd12, 2'b10}) begin
      failures++;
      $display("FAIL drain2 got clr=%b addr=%0d drain=%b rdy=%b exp clr=1 addr=12 drain=1 rdy=0",
               ll_clr_dirty_en, ll_clr_dirty_addr, draining, ll_ready);
    end
    checks++;
    if ({wb_gnt, rf_wr_en, rf_wr_addr} !== {2'b11, 5'd17}) begin
      failures++;
      $display("FAIL drain_wb got gnt=%b en=%b addr=%0d exp gnt=1 en=1 addr=17", wb_gnt, rf_wr_en, rf_wr_addr);
    end
    tick();
    quiet_inputs();
    settle();
    checks++;
    if ({ll_clr_dirty_en, draining, ll_ready, rf_wr_en} !== 4'b0010) begin
      failures++;
      $display("FAIL drain_done got clr=%b drain=%b rdy=%b en=%b exp 0010",
               ll_clr_dirty_en, draining, ll_ready, rf_wr_en);
    end
    tick();
    flush_ll = 1'b1;  // empty FIFO: no drain
    settle();
    tick();
    flush_ll = 1'b0;
    settle();
    checks++;
    if ({ll_clr_dirty_en, draining} !== 2'b00) begin
      failures++;
      $display("FAIL flush_empty got clr=%b drain=%b exp 00", ll_clr_dirty_en, draining);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    fill_two(5'd4, 5'd6);
    flush_ll = 1'b1;
    settle();
    tick();
    flush_ll = 1'b0;
    settle();
    checks++;
    if (draining !== 1'b1) begin
      failures++;
      $display("FAIL rst_drain_pre got draining=%b exp=1", draining);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({draining, ll_clr_dirty_en, rf_wr_en} !== 3'b000) begin
      failures++;
      $display("FAIL rst_drain_async got drain=%b clr=%b en=%b exp 000", draining, ll_clr_dirty_en, rf_wr_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    settle();
    checks++;
    if ({ll_ready, rf_wr_en, draining} !== 3'b100) begin
      failures++;
      $display("FAIL rst_drain_post got rdy=%b en=%b drain=%b exp 100", ll_ready, rf_wr_en, draining);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive_wb(($urandom_range(0, 9) < 6), 5'($urandom));
      if (!(ll_valid && !ll_ready)) drive_ll(($urandom_range(0, 1) == 1), 5'($urandom), $urandom);
      flush_ll = ($urandom_range(0, 19) == 0);
      settle();
      checks++;
      if ({rf_wr_en, rf_wr_tag, rf_wr_addr, rf_wr_data} !== {exp_wr_en, exp_tag, exp_addr, exp_data}) begin
        failures++;
        $display("FAIL rand_rf_port cyc=%0d got en=%b tag=%h addr=%0d data=%h exp en=%b tag=%h addr=%0d data=%h",
                 c, rf_wr_en, rf_wr_tag, rf_wr_addr, rf_wr_data, exp_wr_en, exp_tag, exp_addr, exp_data);
      end
      checks++;
      if ({wb_gnt, ll_ready} !== {exp_gnt, exp_ready}) begin
        failures++;
        $display("FAIL rand_handshake cyc=%0d got gnt=%b rdy=%b exp gnt=%b rdy=%b",
                 c, wb_gnt, ll_ready, exp_gnt, exp_ready);
      end
      checks++;
      if ({ll_clr_dirty_en, ll_clr_dirty_addr, draining} !== {exp_clr_en, exp_clr_addr, exp_drain}) begin
        failures++;
        $display("FAIL rand_clear cyc=%0d got clr=%b addr=%0d drain=%b exp clr=%b addr=%0d drain=%b",
                 c, ll_clr_dirty_en, ll_clr_dirty_addr, draining, exp_clr_en, exp_clr_addr, exp_drain);
      end
      tick();
    end
    quiet_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    quiet_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_priority();
    test_starvation();
    test_full_backpressure();
    test_flush_drain();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
